sequence_generator: RTL
=======================

# sequence_generator

Serial pattern transmitter that drives the one-bit `w` input of the team's Mealy sequence detectors. It latches an N-bit pattern on `start` and shifts it out MSB-first, one bit per clock. The pattern is repeated a programmable number of times, with an optional run of zero bits between repetitions. It sits upstream of the detector as a stimulus source and loopback partner, and reports per-bit validity, busy and completion.

## Interface
- `N`, default 4: pattern width in bits; legal range 2..16.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a transfer. Sampled only in IDLE.
- `pattern`  in  N: bits to send, MSB sent first. Latched on the accepted `start`.
- `reps`  in  4: number of pattern repetitions, 0..15. Latched on the accepted `start`.
- `gap`  in  2: zero bits inserted between repetitions, 0..3. Latched on the accepted `start`.
- `abort`  in  1: synchronous abort; overrides `start`.
- `w`  out  1: serial data bit. Registered.
- `w_valid`  out  1: `w` carries a pattern bit this cycle. Registered.
- `busy`  out  1: high in SEND and GAP. Registered.
- `done`  out  1: one-cycle completion pulse. Registered.

## Operation
- **Reset:** asynchronous assertion forces state IDLE and drives `w`=0, `w_valid`=0, `busy`=0, `done`=0. Shift register, bit counter and repetition counter are all cleared.
- **IDLE:** all outputs are 0. On `start`=1 with `abort`=0:
  - latch `pattern`, `reps` and `gap`.
  - if `reps`≠0, go to SEND.
  - if `reps`=0, go to DONE; no bits are sent.
- **SEND:**
  - each cycle `w` = current MSB of the shift register and `w_valid`=1, then the register shifts left.
  - the bit counter counts 0..N-1.
  - after bit N-1, the repetition counter increments:
    - if repetitions sent = `reps`, go to DONE.
    - else if latched `gap`≠0, go to GAP.
    - else reload the latched pattern and stay in SEND; the next pattern MSB follows with no bubble.
- **GAP:** `w`=0, `w_valid`=0, `busy`=1 for exactly `gap` cycles. Then reload the pattern and go to SEND.
- **DONE:** lasts one cycle with `done`=1, `busy`=0, `w_valid`=0, `w`=0. Always returns to IDLE. `start` is ignored during DONE.
- **`start` outside IDLE:** ignored in SEND, GAP and DONE. Latched values are not disturbed.
- **`abort`:**
  - in SEND or GAP: on the next edge go to IDLE, with all outputs 0 and no `done` pulse.
  - in IDLE or DONE: no effect, except that it blocks `start` in IDLE.
- **Counter widths:**
  - repetition counter is 4 bits; `reps`=15 must complete without wrap.
  - bit counter is ceil(log2 N) bits.
  - gap counter is 2 bits.
- **Output invariants:** `w` is 0 whenever `w_valid`=0. `done` and `busy` are never high together.

## Timing
- `start` accepted at edge k: first bit is on `w` with `w_valid`=1 after edge k+1.
- A transfer occupies `reps`·N + (`reps`−1)·`gap` consecutive busy cycles. `done` follows in the next cycle.
- `start` in the cycle after `done` (back in IDLE) is accepted. Minimum start-to-start spacing is busy cycles + 2.
- `reps`=0: `done` pulses in the cycle after acceptance. `busy` never rises.
- Mid-transfer `reset_n` assertion clears outputs immediately, without waiting for `clk`. After deassertion the block sits in IDLE until a new `start`.
- `abort` and the last-bit edge in the same cycle: `abort` wins, and no `done` pulse is produced.

## Test plan
- **Loopback basic:** reset; `pattern`=1101, `reps`=1, `gap`=0, `start` pulse → `w`=1,1,0,1 on four cycles with `w_valid`=1. Detector `z`=1 on the fourth bit. `done` asserts one cycle later.
- **Back-to-back repetitions:** `pattern`=1101, `reps`=3, `gap`=0 → 12 contiguous valid bits 110111011101. Detector asserts `z` three times. `busy` high for 12 cycles, then `done`.
- **Gap insertion:** `pattern`=1011, `reps`=2, `gap`=2 → `w`=1,0,1,1,0,0,1,0,1,1, with `w_valid` low on the two gap cycles. `busy` high for 10 cycles.
- **Ignored start and abort:** `start` pulsed in mid-SEND → output stream unchanged. `abort` at bit 2 of a `reps`=2 transfer → next cycle IDLE, `w_valid`=0, no `done`.
- **Boundaries:** `reps`=0 → `done` one cycle after `start`, `w_valid` never 1. `reps`=15, `gap`=3, N=4 → 60 valid bits, 42 gap cycles, then exactly one `done`.
- **Reset mid-operation:** assert `reset_n`=0 at bit 1 → `w`, `w_valid` and `busy` drop before the next `clk` edge. After release, a new `start` with `pattern`=1101 sends the full pattern from its MSB.

Source files
------------

// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter feeding the one-bit `w`
// input of the Mealy sequence detectors. Latches an N-bit pattern on
// `start` and shifts it out MSB-first, repeated `reps` times with `gap`
// zero bits between repetitions.
//
// The state register advances on the accepting edge; the registered
// outputs for a state appear on the following edge. A transfer therefore
// shows one all-zero cycle after acceptance, then the bit stream, then a
// single `done` cycle.

module sequence_generator #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] pattern,
    input  logic [3:0]   reps,
    input  logic [1:0]   gap,
    input  logic         abort,
    output logic         w,
    output logic         w_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned BIT_W = (N > 2) ? $clog2(N) : 1;
    localparam int unsigned REP_W = 4;
    localparam int unsigned GAP_W = 2;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [N-1:0]       sreg;
    logic [N-1:0]       pat_q;
    logic [REP_W-1:0]   reps_q;
    logic [GAP_W-1:0]   gap_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [REP_W-1:0]   rep_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    // Transfer FSM with shift register, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sreg    <= '0;
            pat_q   <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        pat_q   <= pattern;
                        sreg    <= pattern;
                        reps_q  <= reps;
                        gap_q   <= gap;
                        bit_cnt <= '0;
                        rep_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= (reps == '0) ? DONE : SEND;
                    end
                end

                SEND: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        w       <= sreg[N-1];
                        w_valid <= 1'b1;
                        busy    <= 1'b1;
                        sreg    <= {sreg[N-2:0], 1'b0};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            rep_cnt <= rep_cnt + REP_W'(1);
                            if (rep_cnt == reps_q - REP_W'(1)) begin
                                state <= DONE;
                            end else if (gap_q != '0) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                // Back-to-back repetition: next MSB follows with no bubble.
                                sreg <= pat_q;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        busy <= 1'b1;
                        if (gap_cnt == gap_q - GAP_W'(1)) begin
                            sreg  <= pat_q;
                            state <= SEND;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
